// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Steps each instruction through fetch, decode, execute, memory and writeback.
// The ALU and the single instruction/data memory port are shared across all
// steps. Memory accesses use a req/ready handshake, and a wait counter traps
// the core if a request stays unanswered for too long.
module rv_multicycle_ctrl #(
    parameter int FETCH_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       reg_write,
    output logic       illegal_insn,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        ALUWB  = 4'd7,
        BEQ    = 4'd8,
        JAL    = 4'd9,
        TRAP   = 4'd10
    } state_t;

    localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (FETCH_TIMEOUT > 0) ? CNT_W'(FETCH_TIMEOUT - 1) : '0;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             timeout_hit;
    logic             illegal_q;

    logic       mem_req_s;
    logic       mem_we_s;
    logic       i_or_d_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] result_src_s;
    logic       reg_write_s;

    // State register; reset always lands in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode. The timeout overrides any other target.
    always_comb begin
        next_state   = state;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        i_or_d_s     = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        result_src_s = 2'b00;
        reg_write_s  = 1'b0;
        waiting      = 1'b0;
        timeout_hit  = 1'b0;

        case (state)
            FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = 2'b01;
                result_src_s = 2'b10;
                if (mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                case (opcode)
                    7'b0000011,
                    7'b0100011: next_state = MEMADR;
                    7'b0110011: next_state = EXEC_R;
                    7'b1100011: next_state = BEQ;
                    7'b1101111: next_state = JAL;
                    default:    next_state = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b10;
                next_state  = opcode[5] ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req_s = 1'b1;
                i_or_d_s  = 1'b1;
                if (mem_ready) begin
                    next_state = MEMWB;
                end
            end
            MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                next_state   = FETCH;
            end
            MEMWR: begin
                mem_req_s = 1'b1;
                mem_we_s  = 1'b1;
                i_or_d_s  = 1'b1;
                if (mem_ready) begin
                    next_state = FETCH;
                end
            end
            EXEC_R: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b10;
                next_state  = ALUWB;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                next_state  = FETCH;
            end
            BEQ: begin
                alu_src_a_s = 2'b10;
                alu_op_s    = 2'b01;
                pc_write_s  = zero;
                next_state  = FETCH;
            end
            JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                pc_write_s  = 1'b1;
                reg_write_s = 1'b1;
                next_state  = FETCH;
            end
            TRAP: begin
                next_state = TRAP;
            end
            default: begin
                next_state = FETCH;
            end
        endcase

        waiting     = mem_req_s & ~mem_ready;
        timeout_hit = (FETCH_TIMEOUT != 0) && waiting && (wait_cnt == CNT_LAST);
        if (timeout_hit) begin
            next_state = TRAP;
        end
    end

    // Memory wait counter: counts unanswered request cycles, restarts otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!waiting || (next_state != state)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Sticky trap flag, raised together with the entry into TRAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (next_state == TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // Outputs are forced low while reset is held. This stops FETCH's request
    // and select values from leaking out during reset, and it drops an
    // in-flight access without waiting for a clock edge.
    assign mem_req      = rst_n & mem_req_s;
    assign mem_we       = rst_n & mem_we_s;
    assign i_or_d       = rst_n & i_or_d_s;
    assign ir_write     = rst_n & ir_write_s;
    assign pc_write     = rst_n & pc_write_s;
    assign reg_write    = rst_n & reg_write_s;
    assign alu_src_a    = rst_n ? alu_src_a_s  : 2'b00;
    assign alu_src_b    = rst_n ? alu_src_b_s  : 2'b00;
    assign alu_op       = rst_n ? alu_op_s     : 2'b00;
    assign result_src   = rst_n ? result_src_s : 2'b00;
    assign illegal_insn = rst_n & illegal_q;
    assign state_o      = state;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl.
// Each test task drives one scenario cycle by cycle and pushes the expected
// state for that cycle into a scoreboard. It then pops the entry and checks
// state_o and the full control vector.
module tb_rv_multicycle_ctrl;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC_R = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_JAL    = 4'd9;
    localparam logic [3:0] S_TRAP   = 4'd10;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = OP_R;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic       reg_write;
    logic       illegal_insn;
    logic [3:0] state_o;

    // Observed control vector, in the same order exp_out builds it.
    logic [14:0] obs;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
        logic       z;
    } sb_item_t;

    sb_item_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.FETCH_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .i_or_d       (i_or_d),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .result_src   (result_src),
        .reg_write    (reg_write),
        .illegal_insn (illegal_insn),
        .state_o      (state_o)
    );

    assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a,
                  alu_src_b, alu_op, result_src, reg_write, illegal_insn};

    // Reference output table: control values expected in each state.
    function automatic logic [14:0] exp_out(input logic [3:0] st, input logic rdy, input logic z);
        logic m_req, m_we, iod, irw, pcw, rw, ill;
        logic [1:0] sa, sb_, op, rs;
        m_req = 0; m_we = 0; iod = 0; irw = 0; pcw = 0; rw = 0; ill = 0;
        sa = 2'b00; sb_ = 2'b00; op = 2'b00; rs = 2'b00;
        case (st)
            S_FETCH:  begin m_req = 1; sb_ = 2'b01; rs = 2'b10; irw = rdy; pcw = rdy; end
            S_DECODE: begin sa = 2'b01; sb_ = 2'b10; end
            S_MEMADR: begin sa = 2'b10; sb_ = 2'b10; end
            S_MEMRD:  begin m_req = 1; iod = 1; end
            S_MEMWB:  begin rs = 2'b01; rw = 1; end
            S_MEMWR:  begin m_req = 1; m_we = 1; iod = 1; end
            S_EXEC_R: begin sa = 2'b10; sb_ = 2'b00; op = 2'b10; end
            S_ALUWB:  begin rs = 2'b00; rw = 1; end
            S_BEQ:    begin sa = 2'b10; sb_ = 2'b00; op = 2'b01; pcw = z; end
            S_JAL:    begin sa = 2'b01; sb_ = 2'b01; pcw = 1; rw = 1; end
            S_TRAP:   begin ill = 1; end
            default:  begin end
        endcase
        return {m_req, m_we, iod, irw, pcw, sa, sb_, op, rs, rw, ill};
    endfunction

    // Applies one cycle of stimulus and queues the expected state for it.
    task automatic drive_cycle(input logic [6:0] op, input logic rdy, input logic z,
                               input logic [3:0] est);
        sb_item_t it;
        @(negedge clk);
        opcode    = op;
        mem_ready = rdy;
        zero      = z;
        it.st  = est;
        it.rdy = rdy;
        it.z   = z;
        sb.push_back(it);
        #1;
    endtask

    task automatic test_reset();
        mem_ready = 1'b1;
        opcode    = OP_R;
        #3;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (state_o !== S_FETCH) begin
                n_bad++;
                $display("[TB] FAIL reset_state %0d: got %0d want %0d", i, state_o, S_FETCH);
            end
            n_cmp++;
            if (obs !== 15'd0) begin
                n_bad++;
                $display("[TB] FAIL reset_outs %0d: got %b want %b", i, obs, 15'd0);
            end
            @(posedge clk);
            #2;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        sb_item_t it;
        logic [3:0] seq [4] = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALUWB};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(OP_R, 1'b1, 1'b0, seq[i]);
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL rtype_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL rtype_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
    endtask

    task automatic test_load_wait();
        sb_item_t it;
        logic [3:0] seq [8] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMRD, S_MEMWB};
        logic       rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            drive_cycle(OP_LOAD, rdy[i], 1'b0, seq[i]);
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL load_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL load_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
    endtask

    task automatic test_store();
        sb_item_t it;
        logic [3:0] seq [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR, S_MEMWR};
        logic       rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive_cycle(OP_STORE, rdy[i], 1'b0, seq[i]);
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL store_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL store_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
    endtask

    task automatic test_beq();
        sb_item_t it;
        logic [3:0] seq [6] = '{S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_DECODE, S_BEQ};
        logic       z   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(OP_BEQ, 1'b1, z[i], seq[i]);
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL beq_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL beq_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
    endtask

    task automatic test_jal_fetch_stall();
        sb_item_t it;
        logic [3:0] seq [4] = '{S_FETCH, S_FETCH, S_DECODE, S_JAL};
        logic       rdy [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(OP_JAL, rdy[i], 1'b0, seq[i]);
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL jal_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL jal_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_item_t it;
        logic [6:0] ops [10] = '{OP_JAL, OP_JAL, OP_JAL, OP_R, OP_R, OP_R, OP_R, OP_BEQ, OP_BEQ, OP_BEQ};
        logic [3:0] seq [10] = '{S_FETCH, S_DECODE, S_JAL, S_FETCH, S_DECODE, S_EXEC_R, S_ALUWB,
                                 S_FETCH, S_DECODE, S_BEQ};
        for (int i = 0; i < 10; i++) begin
            drive_cycle(ops[i], 1'b1, 1'b1, seq[i]);
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL b2b_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL b2b_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
    endtask

    task automatic test_reset_mid_memwr();
        sb_item_t it;
        logic [3:0] seq [4] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWR};
        logic       rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(OP_STORE, rdy[i], 1'b0, seq[i]);
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL rstwr_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL rstwr_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
        // Reset lands mid low phase, well before the next rising edge.
        #1 rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rstwr_mem_req: got %b want 0", mem_req);
        end
        n_cmp++;
        if (mem_we !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL rstwr_mem_we: got %b want 0", mem_we);
        end
        n_cmp++;
        if (state_o !== S_FETCH) begin
            n_bad++;
            $display("[TB] FAIL rstwr_state_async: got %0d want %0d", state_o, S_FETCH);
        end
        n_cmp++;
        if (obs !== 15'd0) begin
            n_bad++;
            $display("[TB] FAIL rstwr_outs_async: got %b want %b", obs, 15'd0);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        sb_item_t it;
        for (int i = 0; i < 22; i++) begin
            drive_cycle(OP_BAD, (i % 3) != 0 ? 1'b1 : 1'b0, 1'b0,
                        (i == 0) ? S_FETCH : (i == 1) ? S_DECODE : S_TRAP);
            if (i == 0) begin
                mem_ready = 1'b1;
                sb[0].rdy = 1'b1;
                #1;
            end
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL illegal_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL illegal_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (illegal_insn !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL illegal_cleared: got %b want 0", illegal_insn);
        end
        n_cmp++;
        if (state_o !== S_FETCH) begin
            n_bad++;
            $display("[TB] FAIL illegal_reset_state: got %0d want %0d", state_o, S_FETCH);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_timeout();
        sb_item_t it;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(OP_R, (i >= 17) ? 1'b1 : 1'b0, 1'b0, (i < 16) ? S_FETCH : S_TRAP);
            it = sb.pop_front();
            n_cmp++;
            if (state_o !== it.st) begin
                n_bad++;
                $display("[TB] FAIL timeout_state step %0d: got %0d want %0d", i, state_o, it.st);
            end
            n_cmp++;
            if (obs !== exp_out(it.st, it.rdy, it.z)) begin
                n_bad++;
                $display("[TB] FAIL timeout_outs step %0d: got %b want %b", i, obs, exp_out(it.st, it.rdy, it.z));
            end
        end
    endtask

    // Guard against the run never completing.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_beq();
        test_jal_fetch_stall();
        test_back_to_back();
        test_reset_mid_memwr();
        test_illegal();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
